// File: rtl/hex_scroll_ctrl.sv
// Six-digit scrolling character controller: rotates a 6-slot code buffer across HEX0..HEX5.
// Optional macro HEX_SCROLL_SYNC_EN adds two-flop synchronizers on run, step and dir.
module hex_scroll_ctrl #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       run,
   input  logic       step,
   input  logic       dir,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [2:0] wr_data,
   output logic [2:0] code0,
   output logic [2:0] code1,
   output logic [2:0] code2,
   output logic [2:0] code3,
   output logic [2:0] code4,
   output logic [2:0] code5,
   output logic [2:0] pos,
   output logic       tick
);

   localparam int unsigned CNT_W  = $clog2(TICK_DIV);
   localparam int unsigned CODE_W = 3;
   localparam int unsigned NSLOT  = 6;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CODE_W-1:0] POS_MAX  = CODE_W'(NSLOT - 1);

   typedef enum logic [1:0] {
      PAUSE = 2'd0,
      RUN   = 2'd1,
      STEP  = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   presc;
   logic               step_q;
   logic               run_i;
   logic               step_i;
   logic               dir_i;
   logic               step_rise;
   logic [CODE_W-1:0]  next_pos;
   logic [CODE_W-1:0]  char_buf [NSLOT];

`ifdef HEX_SCROLL_SYNC_EN
   logic [1:0] run_sync;
   logic [1:0] step_sync;
   logic [1:0] dir_sync;

   // Two-flop synchronizers for the asynchronous control inputs
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         run_sync  <= 2'b00;
         step_sync <= 2'b00;
         dir_sync  <= 2'b00;
      end else begin
         run_sync  <= {run_sync[0],  run};
         step_sync <= {step_sync[0], step};
         dir_sync  <= {dir_sync[0],  dir};
      end
   end

   assign run_i  = run_sync[1];
   assign step_i = step_sync[1];
   assign dir_i  = dir_sync[1];
`else
   assign run_i  = run;
   assign step_i = step;
   assign dir_i  = dir;
`endif

   assign step_rise = step_i & ~step_q;

   // Offset one position left (dir=0) or right (dir=1), wrapping modulo six
   always_comb begin
      next_pos = pos;
      if (dir_i) begin
         next_pos = (pos == '0) ? POS_MAX : CODE_W'(pos - 3'd1);
      end else begin
         next_pos = (pos == POS_MAX) ? '0 : CODE_W'(pos + 3'd1);
      end
   end

   // Mode FSM, prescaler, rotation offset and advance pulse
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state  <= PAUSE;
         presc  <= '0;
         pos    <= '0;
         tick   <= 1'b0;
         step_q <= 1'b0;
      end else begin
         step_q <= step_i;
         tick   <= 1'b0;
         unique case (state)
            PAUSE: begin
               presc <= '0;
               if (run_i) begin
                  state <= RUN;
               end else if (step_rise) begin
                  state <= STEP;
               end
            end
            RUN: begin
               if (presc == CNT_LAST) begin
                  presc <= '0;
                  pos   <= next_pos;
                  tick  <= 1'b1;
               end else begin
                  presc <= CNT_W'(presc + 1'b1);
               end
               if (!run_i) begin
                  state <= PAUSE;
               end
            end
            STEP: begin
               presc <= '0;
               pos   <= next_pos;
               tick  <= 1'b1;
               state <= run_i ? RUN : PAUSE;
            end
            default: begin
               state <= PAUSE;
               presc <= '0;
            end
         endcase
      end
   end

   // Character buffer; writes address physical slots independent of the offset
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int k = 0; k < NSLOT; k++) begin
            char_buf[k] <= CODE_W'(k);
         end
      end else if (wr_en && (wr_addr <= POS_MAX)) begin
         char_buf[wr_addr] <= wr_data;
      end
   end

   function automatic logic [CODE_W-1:0] slot_idx(input logic [CODE_W-1:0] p,
                                                  input logic [CODE_W-1:0] k);
      logic [CODE_W:0] sum;
      sum = (CODE_W+1)'(p) + (CODE_W+1)'(k);
      if (sum >= (CODE_W+1)'(NSLOT)) begin
         sum = (CODE_W+1)'(sum - (CODE_W+1)'(NSLOT));
      end
      return CODE_W'(sum);
   endfunction

   assign code0 = char_buf[slot_idx(pos, 3'd0)];
   assign code1 = char_buf[slot_idx(pos, 3'd1)];
   assign code2 = char_buf[slot_idx(pos, 3'd2)];
   assign code3 = char_buf[slot_idx(pos, 3'd3)];
   assign code4 = char_buf[slot_idx(pos, 3'd4)];
   assign code5 = char_buf[slot_idx(pos, 3'd5)];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Randomized bench for hex_scroll_ctrl (TICK_DIV=4) against a cycle-level behavioural model.
module tb_hex_scroll_ctrl;

   localparam int unsigned DIV = 4;

   logic       CLOCK_50;
   logic       Resetn;
   logic       run;
   logic       step;
   logic       dir;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [2:0] wr_data;
   logic [2:0] code0, code1, code2, code3, code4, code5;
   logic [2:0] pos;
   logic       tick;

   int n_checks;
   int n_fail;

   // Reference model: mode 0 = paused, 1 = running, 2 = single step
   int m_mode;
   int m_cnt;
   int m_pos;
   int m_tick;
   int m_prev_step;
   int m_buf [6];

   hex_scroll_ctrl #(.TICK_DIV(DIV)) dut (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .run      (run),
      .step     (step),
      .dir      (dir),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .code0    (code0),
      .code1    (code1),
      .code2    (code2),
      .code3    (code3),
      .code4    (code4),
      .code5    (code5),
      .pos      (pos),
      .tick     (tick)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_cnt = 0;
      m_pos = 0;
      m_tick = 0;
      m_prev_step = 0;
      for (int k = 0; k < 6; k++) m_buf[k] = k;
   endtask

   task automatic model_edge();
      int adv;
      adv = 0;
      case (m_mode)
         0: begin
            m_cnt = 0;
            if (run) m_mode = 1;
            else if (step && m_prev_step == 0) m_mode = 2;
         end
         1: begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DIV) begin
               m_cnt = 0;
               adv = 1;
            end
            if (!run) m_mode = 0;
         end
         default: begin
            m_cnt = 0;
            adv = 1;
            m_mode = run ? 1 : 0;
         end
      endcase
      if (adv != 0) m_pos = dir ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
      m_tick = adv;
      m_prev_step = int'(step);
      if (wr_en && wr_addr <= 3'd5) m_buf[wr_addr] = int'(wr_data);
   endtask

   task automatic check_all();
      logic [2:0] codes [6];
      codes = '{code0, code1, code2, code3, code4, code5};
      check_eq("pos", 32'(pos), 32'(m_pos));
      check_eq("tick", 32'(tick), 32'(m_tick));
      for (int k = 0; k < 6; k++) begin
         check_eq($sformatf("code%0d", k), 32'(codes[k]), 32'(m_buf[(k + m_pos) % 6]));
      end
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK_50);
         model_edge();
         @(negedge CLOCK_50);
         check_all();
      end
   endtask

   initial begin
      int guard;
      n_checks = 0;
      n_fail = 0;
      Resetn = 1'b0;
      run = 1'b0;
      step = 1'b0;
      dir = 1'b0;
      wr_en = 1'b0;
      wr_addr = 3'd0;
      wr_data = 3'd0;
      model_reset();
      repeat (2) @(negedge CLOCK_50);
      check_all();
      Resetn = 1'b1;
      cycle(2);

      // Auto-rotate left, then right
      run = 1'b1;
      cycle(12);
      dir = 1'b1;
      cycle(10);

      // Step held high while paused yields a single advance
      run = 1'b0;
      dir = 1'b0;
      cycle(3);
      step = 1'b1;
      cycle(10);
      step = 1'b0;
      cycle(2);

      // Physical-slot write, then an ignored out-of-range write
      wr_en = 1'b1;
      wr_addr = 3'd2;
      wr_data = 3'd7;
      cycle(1);
      wr_addr = 3'd6;
      wr_data = 3'd3;
      cycle(1);
      wr_addr = 3'd7;
      cycle(1);
      wr_en = 1'b0;
      cycle(1);

      // Pause mid-count discards the partial count
      run = 1'b1;
      cycle(7);
      run = 1'b0;
      cycle(3);
      run = 1'b1;
      cycle(10);

      // Reset asserted mid-run at offset 3
      guard = 0;
      while (pos != 3'd3 && guard < 60) begin
         cycle(1);
         guard++;
      end
      check_eq("reach_pos3", 32'(pos), 32'd3);
      Resetn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_all();
      Resetn = 1'b1;
      cycle(10);

      // Random mix of run/step/dir/writes
      run = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step = ($urandom_range(0, 3) == 0);
         dir = 1'($urandom_range(0, 1));
         wr_en = ($urandom_range(0, 3) == 0);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 3'($urandom_range(0, 7));
         cycle(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
